ifu_fetch_queue: RTL and testbench
==================================

Name: ifu_fetch_queue

Overview:
Parametrised instruction-fetch front end that replaces the single-cycle combinational fetch.
- Owns the fetch PC and issues sequential word fetches over a request/response memory port with variable latency.
- Buffers returned instructions in a DEPTH-entry FIFO and presents them downstream on a valid/ready interface.
- Supports PC redirect (flush) and detects ebreak to halt fetch.

Parameters:
XLEN, 32, PC/instruction width (only 32 supported)
DEPTH, 4, instruction FIFO entries (power of 2, >=2)
RESET_PC, 32'h8000_0000, fetch PC after reset
EBREAK_INST, 32'h0010_0073, encoding treated as ebreak

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
mem_req_valid  out  1  fetch request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  XLEN  fetch address (word aligned)
mem_resp_valid  in  1  response data valid (one per accepted request, in order)
mem_resp_data  in  XLEN  fetched instruction
redirect_valid  in  1  flush and restart fetch at redirect_pc
redirect_pc  in  XLEN  new fetch PC (bits[1:0] ignored, forced 0)
out_valid  out  1  instruction available
out_ready  in  1  downstream accepts
out_pc  out  XLEN  PC of head instruction
out_inst  out  XLEN  head instruction
halt  out  1  sticky; ebreak consumed

Behaviour:
- Reset (rst=1 at clk edge):
  - fetch_pc=RESET_PC; FIFO empty.
  - out_valid=0, mem_req_valid=0, halt=0, discard=0, inflight=0.
  - Internal state held in reset while rst=1.
  - rst overrides all other inputs.
- One outstanding request max.
- Request issue:
  - mem_req_valid=1 when !inflight && !halt && !halting && free slots > 0. Free slots count entries plus the reserved inflight slot.
  - mem_req_addr=fetch_pc.
  - On mem_req_valid&&mem_req_ready: inflight<=1, fetch_pc<=fetch_pc+4. Wraps modulo 2^XLEN.
- Response (mem_resp_valid && inflight):
  - inflight<=0.
  - If discard=1: data dropped, discard<=0.
  - Else: push {pc, data} into FIFO.
  - Response arriving while inflight=0 is ignored.
  - Zero-latency response in same cycle as request acceptance is not permitted; the earliest response is the cycle after acceptance.
- Output:
  - out_valid = FIFO non-empty && !halt; out_pc/out_inst = head entry.
  - Pop on out_valid&&out_ready.
  - Push and pop in the same cycle are allowed when full: no overflow, count unchanged.
- Redirect (redirect_valid=1, takes priority over a same-cycle push and pop):
  - FIFO cleared; fetch_pc<=redirect_pc&~3.
  - If a request is inflight with no response this cycle, discard<=1.
  - A request accepted in the redirect cycle is also marked discard.
  - halting cleared; halt unaffected.
- Ebreak:
  - When the popped entry's inst==EBREAK_INST: halt<=1 (sticky until rst).
  - Fetch also stops issuing once an ebreak is pushed (halting flag) to avoid prefetch past it.
  - After halt: out_valid=0, mem_req_valid=0.
  - halting clears on redirect.
- Latency: first instruction out_valid no earlier than 2 cycles after reset deassert with a 1-cycle memory.
- Throughput: 1 instruction per (memory latency + 1) cycles.

Optional Feature:
EBREAK_DPI_EN
- Defined: the block imports DPI-C void ebreak() and calls it exactly once, in the cycle halt rises (pop of the ebreak entry).
- Undefined: no DPI import; halt output only.
- RTL otherwise identical.

Test Plan:
- Reset deassert, memory 1-cycle latency returning 0x00000013 (nop) -> first request addr 0x80000000, out_pc sequence 0x80000000, 0x80000004, ... with out_ready=1.
- out_ready=0, DEPTH=4 -> exactly 4 entries fetched, no 5th request; raise out_ready -> drains in order, fetch resumes.
- Redirect to 0x80001002 while request inflight -> stale response dropped, FIFO empty, next request addr 0x80001000.
- Memory returns 0x00100073 at 0x80000008 -> no requests after it; halt=1 the cycle after its pop; out_valid=0 thereafter.
- fetch_pc 0xFFFFFFFC -> next addr 0x00000000.
- rst asserted mid-fetch with a response pending -> state returns to reset values, late response ignored, fetch restarts at 0x80000000.

Source files
------------

// File: rtl/ifu_fetch_queue.sv
// ---------------------------------------------------------------------------
// ifu_fetch_queue
//
// Instruction-fetch front end. Owns the fetch PC, issues sequential word
// fetches over a request/response memory port (one request outstanding at a
// time, variable latency), buffers returned instructions in a DEPTH-entry
// FIFO and presents them downstream on a valid/ready interface. Supports a
// PC redirect that flushes everything fetched so far, and stops fetching at
// an ebreak, raising a sticky halt once the ebreak is consumed downstream.
//
// Parameters:
//   XLEN        PC / instruction width (only 32 supported)
//   DEPTH       instruction FIFO entries (power of 2, >= 2)
//   RESET_PC    fetch PC after reset
//   EBREAK_INST encoding treated as ebreak
//
// Ports:
//   clk             in   rising-edge clock
//   rst             in   synchronous active-high reset
//   mem_req_valid   out  fetch request valid
//   mem_req_ready   in   memory accepts request
//   mem_req_addr    out  fetch address (word aligned)
//   mem_resp_valid  in   response valid (one per accepted request, in order)
//   mem_resp_data   in   fetched instruction
//   redirect_valid  in   flush and restart fetch at redirect_pc
//   redirect_pc     in   new fetch PC (bits [1:0] forced to zero)
//   out_valid       out  instruction available
//   out_ready       in   downstream accepts
//   out_pc          out  PC of head instruction
//   out_inst        out  head instruction
//   halt            out  sticky; set when an ebreak is consumed
// ---------------------------------------------------------------------------
module ifu_fetch_queue #(
  parameter int              XLEN        = 32,
  parameter int              DEPTH       = 4,
  parameter logic [XLEN-1:0] RESET_PC    = 32'h8000_0000,
  parameter logic [XLEN-1:0] EBREAK_INST = 32'h0010_0073
) (
  input  logic            clk,
  input  logic            rst,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_inst,
  output logic            halt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  // Fetch-side state
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] req_pc;
  logic            inflight;
  logic            discard;
  logic            halting;

  // Instruction FIFO
  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] inst_mem [DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [CW-1:0]   count;

  // Per-cycle events
  logic            req_fire;
  logic            resp_take;
  logic            push;
  logic            pop;
  logic            push_ebreak;
  logic            pop_ebreak;
  logic            stale_next;
  logic [XLEN-1:0] redirect_aligned;

  // The low two bits of the redirect target are deliberately dropped.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_aligned     = {redirect_pc[XLEN-1:2], 2'b00};

  // Request/response/FIFO handshakes. Redirect suppresses both push and pop:
  // the FIFO is being cleared that cycle, so neither may take effect.
  // A request needs a free FIFO slot for its eventual response; since only
  // one request is ever outstanding, that is simply count < DEPTH here.
  always_comb begin
    mem_req_valid = 1'b0;
    out_valid     = 1'b0;
    req_fire      = 1'b0;
    resp_take     = 1'b0;
    push          = 1'b0;
    pop           = 1'b0;
    push_ebreak   = 1'b0;
    pop_ebreak    = 1'b0;
    stale_next    = 1'b0;

    mem_req_valid = !rst && !inflight && !halt && !halting && (count < FULL_COUNT);
    out_valid     = !rst && (count != '0) && !halt;

    req_fire  = mem_req_valid && mem_req_ready;
    resp_take = mem_resp_valid && inflight;
    push      = resp_take && !discard && !redirect_valid;
    pop       = out_valid && out_ready && !redirect_valid;

    push_ebreak = push && (mem_resp_data == EBREAK_INST);
    pop_ebreak  = pop && (inst_mem[rd_ptr] == EBREAK_INST);

    // On redirect, whatever request is still unanswered after this edge
    // (old one with no response yet, or one accepted right now) is stale.
    stale_next = req_fire || (inflight && !mem_resp_valid);
  end

  assign mem_req_addr = fetch_pc;
  assign out_pc       = pc_mem[rd_ptr];
  assign out_inst     = inst_mem[rd_ptr];

  // Fetch PC, outstanding-request tracking and the discard flag. req_pc keeps
  // the address of the outstanding request so the response can be tagged
  // with it when pushed.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
      inflight <= 1'b0;
      discard  <= 1'b0;
    end else begin
      if (redirect_valid) begin
        fetch_pc <= redirect_aligned;
      end else if (req_fire) begin
        fetch_pc <= fetch_pc + XLEN'(4);
      end

      if (req_fire) begin
        inflight <= 1'b1;
        req_pc   <= fetch_pc;
      end else if (resp_take) begin
        inflight <= 1'b0;
      end

      if (redirect_valid && stale_next) begin
        discard <= 1'b1;
      end else if (resp_take) begin
        discard <= 1'b0;
      end
    end
  end

  // FIFO pointers and occupancy. A simultaneous push and pop leaves the
  // count unchanged, which also covers the full case.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (push && !pop) begin
        count <= count + CW'(1);
      end else if (pop && !push) begin
        count <= count - CW'(1);
      end
    end
  end

  // FIFO storage needs no reset: nothing is read before it is written.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      pc_mem[wr_ptr]   <= req_pc;
      inst_mem[wr_ptr] <= mem_resp_data;
    end
  end

  // halting stops prefetch past an ebreak as soon as it is buffered; halt
  // itself only rises once the ebreak is consumed, and only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      halting <= 1'b0;
      halt    <= 1'b0;
    end else begin
      if (redirect_valid) begin
        halting <= 1'b0;
      end else if (push_ebreak) begin
        halting <= 1'b1;
      end

      if (pop_ebreak) begin
        halt <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_ifu_fetch_queue
//
// Randomized bench for ifu_fetch_queue. A behavioural memory answers each
// accepted request after 1..3 cycles (and occasionally sends unsolicited
// responses that must be ignored). A transaction-level reference model keeps
// the expected instruction queue as a SystemVerilog queue and predicts every
// DUT output each cycle.
// ---------------------------------------------------------------------------
module tb_ifu_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam int          CYCLES   = 6000;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req_valid;
  logic        mem_req_ready;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_inst;
  logic        halt;

  always #5 clk = ~clk;

  ifu_fetch_queue #(
    .XLEN(32),
    .DEPTH(DEPTH),
    .RESET_PC(RESET_PC),
    .EBREAK_INST(EBREAK)
  ) dut (
    .clk(clk),
    .rst(rst),
    .mem_req_valid(mem_req_valid),
    .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_inst(out_inst),
    .halt(halt)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  // Reference model: buffered instructions plus what the fetcher is doing.
  entry_t      m_q[$];
  logic [31:0] m_pc;
  logic [31:0] m_req_pc;
  bit          m_busy;
  bit          m_stale;
  bit          m_halted;
  bit          m_no_fetch;

  // Behavioural memory
  bit          mem_pending;
  int          mem_due;
  bit          spur_next;

  int compared   = 0;
  int mismatched = 0;
  int cycle      = 0;
  int halted_cycles = 0;
  int rst_hold   = 0;

  task checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s cycle=%0d got=%h expected=%h", tag, cycle, got, exp);
    end
  endtask

  task applyStimulus(input logic r, input logic rdy, input logic rv, input logic [31:0] rd,
                     input logic redir, input logic [31:0] rpc, input logic ordy);
    rst            = r;
    mem_req_ready  = rdy;
    mem_resp_valid = rv;
    mem_resp_data  = rd;
    redirect_valid = redir;
    redirect_pc    = rpc;
    out_ready      = ordy;
  endtask

  task modelReset();
    m_q.delete();
    m_pc       = RESET_PC;
    m_req_pc   = RESET_PC;
    m_busy     = 0;
    m_stale    = 0;
    m_halted   = 0;
    m_no_fetch = 0;
  endtask

  function automatic bit expReqValid();
    return !rst && !m_busy && !m_halted && !m_no_fetch && (m_q.size() < DEPTH);
  endfunction

  function automatic bit expOutValid();
    return !rst && (m_q.size() > 0) && !m_halted;
  endfunction

  task checkAll();
    checkOutput("req_valid", 32'(mem_req_valid), 32'(expReqValid()));
    checkOutput("req_addr", mem_req_addr, m_pc);
    checkOutput("out_valid", 32'(out_valid), 32'(expOutValid()));
    checkOutput("halt", 32'(halt), 32'(m_halted));
    if (expOutValid()) begin
      checkOutput("out_pc", out_pc, m_q[0].pc);
      checkOutput("out_inst", out_inst, m_q[0].inst);
    end
  endtask

  // Advance the model by one clock edge using the inputs that were driven.
  // Returns whether a request was accepted on this edge.
  task modelStep(output bit fire);
    bit     took;
    bit     popped;
    entry_t e;
    fire = 0;
    if (rst) begin
      modelReset();
    end else begin
      fire   = expReqValid() && mem_req_ready;
      took   = mem_resp_valid && m_busy;
      popped = expOutValid() && out_ready && !redirect_valid;
      if (redirect_valid) begin
        m_q.delete();
        m_no_fetch = 0;
        m_stale = fire || (m_busy && !mem_resp_valid);
        if (fire) begin
          m_busy   = 1;
          m_req_pc = m_pc;
        end else if (took) begin
          m_busy = 0;
        end
        m_pc = redirect_pc & 32'hFFFF_FFFC;
      end else begin
        if (popped) begin
          e = m_q.pop_front();
          if (e.inst == EBREAK) m_halted = 1;
        end
        if (took) begin
          m_busy = 0;
          if (m_stale) begin
            m_stale = 0;
          end else begin
            m_q.push_back('{pc: m_req_pc, inst: mem_resp_data});
            if (mem_resp_data == EBREAK) m_no_fetch = 1;
          end
        end
        if (fire) begin
          m_busy   = 1;
          m_req_pc = m_pc;
          m_pc     = m_pc + 32'd4;
        end
      end
    end
  endtask

  initial begin
    bit          r, rdy, rv, redir, ordy, fire;
    logic [31:0] rd, rpc;
    int          mode;

    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    modelReset();
    mem_pending = 0;
    spur_next   = 0;
    repeat (3) @(posedge clk);

    // Reset state, independent of the model.
    @(negedge clk);
    #1;
    checkOutput("rst_req_valid", 32'(mem_req_valid), 32'd0);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_halt", 32'(halt), 32'd0);
    checkOutput("rst_addr", mem_req_addr, 32'h8000_0000);

    // First cycle out of reset: first fetch goes to the reset PC.
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    #1;
    checkOutput("first_req_valid", 32'(mem_req_valid), 32'd1);
    checkOutput("first_req_addr", mem_req_addr, 32'h8000_0000);
    @(posedge clk);
    modelStep(fire);

    for (int c = 0; c < CYCLES; c++) begin
      @(negedge clk);
      cycle = c;

      // Reset: occasionally at random, and always after a while halted.
      if (rst_hold > 0) begin
        r = 1;
        rst_hold--;
      end else if (halted_cycles > 15 || $urandom_range(0, 299) == 0) begin
        r = 1;
        rst_hold = $urandom_range(0, 1);
      end else begin
        r = 0;
      end

      rdy = ($urandom_range(0, 3) != 0);

      rv = 0;
      rd = $urandom;
      if (mem_pending && c == mem_due) begin
        rv = 1;
        rd = ($urandom_range(0, 9) == 0) ? EBREAK : $urandom;
        mem_pending = 0;
      end else if (!mem_pending && (spur_next || $urandom_range(0, 15) == 0)) begin
        rv = 1;
        spur_next = 0;
      end

      redir = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF4 + 32'($urandom_range(0, 11));
      else if ($urandom_range(0, 3) == 0) rpc = 32'h8000_1002;
      else rpc = $urandom;

      mode = (c / 50) % 3;
      if (mode == 0) ordy = ($urandom_range(0, 3) != 0);
      else if (mode == 1) ordy = 0;
      else ordy = $urandom_range(0, 1) == 1;

      applyStimulus(r, rdy, rv, rd, redir, rpc, ordy);
      #1;
      checkAll();

      @(posedge clk);
      modelStep(fire);
      if (fire) begin
        mem_pending = 1;
        mem_due = c + 1 + $urandom_range(0, 2);
      end
      if (r) begin
        // A response still owed by memory arrives late, after reset.
        if (mem_pending) spur_next = 1;
        mem_pending = 0;
      end
      if (m_halted) halted_cycles++;
      else halted_cycles = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
